// File: rtl/acu_sequencer.sv
// acu_sequencer: program sequencer feeding the accumulator ALU.
// Fetches 24-bit words from a synchronous ROM (one cycle read latency),
// issues opcode/immediate pairs to the ALU, resolves JMP/JZ/JNZ and stops on HALT.
// A small settle counter holds conditional branches in DECODE until the
// ALU zero flag reflects the most recently issued op.
module acu_sequencer #(
  parameter int AW         = 8,
  parameter int START_ADDR = 0,
  parameter int ZERO_LAT   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] instr_addr,
  input  logic [23:0]   instr_rdata,
  output logic [7:0]    op,
  output logic [15:0]   data_in,
  output logic          op_valid,
  input  logic          zero,
  output logic          busy,
  output logic          halted,
  output logic [15:0]   issue_cnt
);

  // Opcodes the sequencer consumes itself; everything else goes to the ALU.
  localparam logic [7:0] OPC_NOP  = 8'h00;
  localparam logic [7:0] OPC_JMP  = 8'hF0;
  localparam logic [7:0] OPC_JZ   = 8'hF1;
  localparam logic [7:0] OPC_JNZ  = 8'hF2;
  localparam logic [7:0] OPC_HALT = 8'hFF;

  localparam logic [AW-1:0] START_PC    = AW'(START_ADDR);
  localparam logic [2:0]    SETTLE_INIT = 3'(ZERO_LAT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_HALT
  } state_t;

  state_t        state_reg,    state_next;
  logic [AW-1:0] pc_reg,       pc_next;
  logic [7:0]    op_reg,       op_next;
  logic [15:0]   data_reg,     data_next;
  logic          op_valid_reg, op_valid_next;
  logic [15:0]   issue_cnt_reg, issue_cnt_next;
  logic [2:0]    settle_reg,   settle_next;

  // Fields of the word currently presented by the ROM (valid in DECODE).
  logic [7:0]    opcode;
  logic [15:0]   imm;
  logic [AW-1:0] target;
  logic [AW-1:0] pc_inc;
  logic          branch_taken;

  assign opcode = instr_rdata[23:16];
  assign imm    = instr_rdata[15:0];
  assign target = imm[AW-1:0];
  assign pc_inc = pc_reg + AW'(1);

  // JZ jumps on zero=1, JNZ on zero=0; only meaningful when a branch is evaluated.
  assign branch_taken = (opcode == OPC_JZ) ? zero : ~zero;

  // State and datapath registers; async reset returns every output to idle values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      pc_reg        <= START_PC;
      op_reg        <= 8'h00;
      data_reg      <= 16'h0000;
      op_valid_reg  <= 1'b0;
      issue_cnt_reg <= 16'h0000;
      settle_reg    <= 3'd0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      op_reg        <= op_next;
      data_reg      <= data_next;
      op_valid_reg  <= op_valid_next;
      issue_cnt_reg <= issue_cnt_next;
      settle_reg    <= settle_next;
    end
  end

  // Next-state and next-output decode for the fetch/decode/halt sequencer.
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    op_next        = 8'h00;          // op reads as NOP whenever nothing is issued
    data_next      = data_reg;       // operand holds its last issued value
    op_valid_next  = 1'b0;
    issue_cnt_next = issue_cnt_reg;
    // Settle counter drains one per cycle; an issue below reloads it.
    settle_next    = (settle_reg != 3'd0) ? settle_reg - 3'd1 : settle_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          pc_next    = START_PC;
          state_next = S_FETCH;
        end
      end

      S_FETCH: begin
        // ROM samples instr_addr on this edge; its word is valid in DECODE.
        state_next = S_DECODE;
      end

      S_DECODE: begin
        case (opcode)
          OPC_NOP: begin
            pc_next    = pc_inc;
            state_next = S_FETCH;
          end
          OPC_JMP: begin
            pc_next    = target;
            state_next = S_FETCH;
          end
          OPC_JZ, OPC_JNZ: begin
            // Hold in DECODE (PC unchanged, ROM re-presents the word) until
            // the zero flag reflects the last issued op.
            if (settle_reg == 3'd0) begin
              pc_next    = branch_taken ? target : pc_inc;
              state_next = S_FETCH;
            end
          end
          OPC_HALT: begin
            state_next = S_HALT;
          end
          default: begin
            op_next        = opcode;
            data_next      = imm;
            op_valid_next  = 1'b1;
            issue_cnt_next = issue_cnt_reg + 16'd1;
            settle_next    = SETTLE_INIT;
            pc_next        = pc_inc;
            state_next     = S_FETCH;
          end
        endcase
      end

      S_HALT: begin
        // Restart leaves the settle counter running so a pending flag is honoured.
        if (start) begin
          pc_next    = START_PC;
          state_next = S_FETCH;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign instr_addr = pc_reg;
  assign op         = op_reg;
  assign data_in    = data_reg;
  assign op_valid   = op_valid_reg;
  assign issue_cnt  = issue_cnt_reg;
  assign busy       = (state_reg == S_FETCH) || (state_reg == S_DECODE);
  assign halted     = (state_reg == S_HALT);

endmodule

// File: tb/tb_acu_sequencer.sv
// Directed bench for acu_sequencer: three instances share one program ROM image
// (defaults, ZERO_LAT=3, START_ADDR=0xFE); each has its own registered ROM read.
module tb_acu_sequencer;

  logic clk;
  logic rst;

  logic [23:0] rom [0:255];

  // Instance A: default parameters
  logic        start_a, zero_a, op_valid_a, busy_a, halted_a;
  logic [7:0]  addr_a, op_a;
  logic [23:0] rdata_a;
  logic [15:0] data_a, cnt_a;

  // Instance B: ZERO_LAT=3
  logic        start_b, zero_b, op_valid_b, busy_b, halted_b;
  logic [7:0]  addr_b, op_b;
  logic [23:0] rdata_b;
  logic [15:0] data_b, cnt_b;

  // Instance C: START_ADDR=0xFE
  logic        start_c, zero_c, op_valid_c, busy_c, halted_c;
  logic [7:0]  addr_c, op_c;
  logic [23:0] rdata_c;
  logic [15:0] data_c, cnt_c;

  int total;
  int bad;

  acu_sequencer dut_a (
    .clk(clk), .rst(rst), .start(start_a), .instr_addr(addr_a), .instr_rdata(rdata_a),
    .op(op_a), .data_in(data_a), .op_valid(op_valid_a), .zero(zero_a),
    .busy(busy_a), .halted(halted_a), .issue_cnt(cnt_a)
  );

  acu_sequencer #(.ZERO_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .instr_addr(addr_b), .instr_rdata(rdata_b),
    .op(op_b), .data_in(data_b), .op_valid(op_valid_b), .zero(zero_b),
    .busy(busy_b), .halted(halted_b), .issue_cnt(cnt_b)
  );

  acu_sequencer #(.START_ADDR(8'hFE)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .instr_addr(addr_c), .instr_rdata(rdata_c),
    .op(op_c), .data_in(data_c), .op_valid(op_valid_c), .zero(zero_c),
    .busy(busy_c), .halted(halted_c), .issue_cnt(cnt_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM model: one cycle read latency per instance
  always @(posedge clk) begin
    rdata_a <= rom[addr_a];
    rdata_b <= rom[addr_b];
    rdata_c <= rom[addr_c];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Run the two-word branch program on instance A from HALT/IDLE and check the
  // address fetched right after the branch resolves.
  task automatic run_branch(input string tag, input logic [23:0] br, input logic zv,
                            input logic [7:0] exp_addr, input logic [15:0] exp_cnt);
    rom[1] = br;
    zero_a = zv;
    start_a = 1'b1;
    tick();                       // FETCH addr 0
    start_a = 1'b0;
    tick();                       // DECODE ALU op
    tick();                       // issue, FETCH addr 1
    tick();                       // DECODE branch
    tick();                       // branch resolved
    check({tag, "_addr"}, 32'(addr_a), 32'(exp_addr));
    check({tag, "_busy"}, 32'(busy_a), 32'd1);
    for (int i = 0; i < 20 && !halted_a; i++) tick();
    check({tag, "_halt"}, 32'(halted_a), 32'd1);
    check({tag, "_cnt"}, 32'(cnt_a), 32'(exp_cnt));
    $display("branch %s: instr=%h zero=%0d addr=%h", tag, br, zv, exp_addr);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    zero_a = 1'b0;  zero_b = 1'b0;  zero_c = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 24'hFF0000;

    // ---- Reset values ----
    #2;
    check("rst_addr_a", 32'(addr_a), 32'h00);
    check("rst_op_a", 32'(op_a), 32'h00);
    check("rst_data_a", 32'(data_a), 32'h0000);
    check("rst_valid_a", 32'(op_valid_a), 32'd0);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_halted_a", 32'(halted_a), 32'd0);
    check("rst_cnt_a", 32'(cnt_a), 32'd0);
    check("rst_addr_c", 32'(addr_c), 32'hFE);
    $display("reset: addr_a=%h addr_c=%h", addr_a, addr_c);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("idle_busy_a", 32'(busy_a), 32'd0);

    // ---- Linear program ----
    rom[0] = 24'h010005;
    rom[1] = 24'h020003;
    rom[2] = 24'hFF0000;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("lin_fetch_busy", 32'(busy_a), 32'd1);
    check("lin_fetch_addr", 32'(addr_a), 32'h00);
    tick();
    check("lin_dec_valid", 32'(op_valid_a), 32'd0);
    tick();
    check("lin_iss1_valid", 32'(op_valid_a), 32'd1);
    check("lin_iss1_op", 32'(op_a), 32'h01);
    check("lin_iss1_data", 32'(data_a), 32'h0005);
    check("lin_iss1_cnt", 32'(cnt_a), 32'd1);
    check("lin_iss1_addr", 32'(addr_a), 32'h01);
    $display("issue: op=%h data=%h cnt=%0d", op_a, data_a, cnt_a);
    tick();
    check("lin_gap_valid", 32'(op_valid_a), 32'd0);
    check("lin_gap_op", 32'(op_a), 32'h00);
    check("lin_gap_data", 32'(data_a), 32'h0005);
    tick();
    check("lin_iss2_valid", 32'(op_valid_a), 32'd1);
    check("lin_iss2_op", 32'(op_a), 32'h02);
    check("lin_iss2_data", 32'(data_a), 32'h0003);
    check("lin_iss2_cnt", 32'(cnt_a), 32'd2);
    $display("issue: op=%h data=%h cnt=%0d", op_a, data_a, cnt_a);
    tick();
    check("lin_gap2_op", 32'(op_a), 32'h00);
    tick();
    check("lin_halted", 32'(halted_a), 32'd1);
    check("lin_halt_busy", 32'(busy_a), 32'd0);
    check("lin_halt_addr", 32'(addr_a), 32'h02);
    check("lin_halt_cnt", 32'(cnt_a), 32'd2);
    tick();
    check("lin_halt_stay", 32'(halted_a), 32'd1);
    $display("halt: addr=%h cnt=%0d", addr_a, cnt_a);

    // ---- Restart from HALT, start held while busy ----
    start_a = 1'b1;
    tick();
    check("rs_addr0", 32'(addr_a), 32'h00);
    check("rs_busy", 32'(busy_a), 32'd1);
    tick();
    check("rs_dec_addr", 32'(addr_a), 32'h00);
    tick();
    check("rs_iss_addr", 32'(addr_a), 32'h01);
    check("rs_iss_op", 32'(op_a), 32'h01);
    check("rs_iss_cnt", 32'(cnt_a), 32'd3);
    start_a = 1'b0;
    tick();
    check("rs_dec2_addr", 32'(addr_a), 32'h01);
    for (int i = 0; i < 20 && !halted_a; i++) tick();
    check("rs_halted", 32'(halted_a), 32'd1);
    check("rs_cnt", 32'(cnt_a), 32'd4);
    check("rs_halt_addr", 32'(addr_a), 32'h02);
    $display("restart: addr=%h cnt=%0d", addr_a, cnt_a);

    // ---- Branch taken / not taken ----
    rom[0]     = 24'h030000;
    rom[2]     = 24'hFF0000;
    rom[8'h10] = 24'hFF0000;
    run_branch("jz_t",  24'hF10010, 1'b1, 8'h10, 16'd5);
    run_branch("jz_n",  24'hF10010, 1'b0, 8'h02, 16'd6);
    run_branch("jnz_n", 24'hF20010, 1'b1, 8'h02, 16'd7);
    run_branch("jnz_t", 24'hF20010, 1'b0, 8'h10, 16'd8);
    zero_a = 1'b0;

    // ---- Unconditional jump with target bits above AW ignored ----
    rom[1] = 24'hF0AB20;
    rom[8'h20] = 24'hFF0000;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick(); tick(); tick(); tick();
    check("jmp_addr", 32'(addr_a), 32'h20);
    for (int i = 0; i < 20 && !halted_a; i++) tick();
    check("jmp_halted", 32'(halted_a), 32'd1);
    $display("jmp: addr=%h", addr_a);

    // ---- Settle stall on instance B (ZERO_LAT=3) ----
    rom[1] = 24'hF10010;
    zero_b = 1'b0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick();
    tick();
    check("st_iss_valid", 32'(op_valid_b), 32'd1);
    check("st_iss_addr", 32'(addr_b), 32'h01);
    tick();                       // DECODE of JZ, counter 2
    tick();                       // stall
    check("st_stall1_addr", 32'(addr_b), 32'h01);
    check("st_stall1_busy", 32'(busy_b), 32'd1);
    tick();                       // stall
    check("st_stall2_addr", 32'(addr_b), 32'h01);
    zero_b = 1'b1;                // only the final DECODE edge should see this
    tick();
    check("st_resolved", 32'(addr_b), 32'h10);
    zero_b = 1'b0;
    for (int i = 0; i < 20 && !halted_b; i++) tick();
    check("st_halted", 32'(halted_b), 32'd1);
    $display("settle: addr=%h cnt=%0d", addr_b, cnt_b);

    // ---- PC wrap on instance C (START_ADDR=0xFE) ----
    rom[8'hFE] = 24'h000000;
    rom[8'hFF] = 24'h050007;
    rom[0]     = 24'hFF0000;
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    check("wr_addr_fe", 32'(addr_c), 32'hFE);
    tick();
    tick();
    check("wr_addr_ff", 32'(addr_c), 32'hFF);
    check("wr_nop_valid", 32'(op_valid_c), 32'd0);
    tick();
    tick();
    check("wr_iss_valid", 32'(op_valid_c), 32'd1);
    check("wr_iss_op", 32'(op_c), 32'h05);
    check("wr_iss_data", 32'(data_c), 32'h0007);
    check("wr_addr_00", 32'(addr_c), 32'h00);
    tick();
    tick();
    check("wr_halted", 32'(halted_c), 32'd1);
    check("wr_cnt", 32'(cnt_c), 32'd1);
    $display("wrap: addr=%h cnt=%0d", addr_c, cnt_c);

    // ---- Async reset mid-run on instance A ----
    rom[0] = 24'h010005;
    rom[1] = 24'h020003;
    rom[2] = 24'hFF0000;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    check("ar_pre_valid", 32'(op_valid_a), 32'd1);
    check("ar_pre_cnt", 32'(cnt_a), 32'd10);
    rst = 1'b1;
    #1;
    check("ar_valid", 32'(op_valid_a), 32'd0);
    check("ar_cnt", 32'(cnt_a), 32'd0);
    check("ar_addr", 32'(addr_a), 32'h00);
    check("ar_op", 32'(op_a), 32'h00);
    check("ar_busy", 32'(busy_a), 32'd0);
    check("ar_halted", 32'(halted_a), 32'd0);
    check("ar_addr_c", 32'(addr_c), 32'hFE);
    $display("async reset: valid=%0d cnt=%0d addr=%h", op_valid_a, cnt_a, addr_a);
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("ar_idle_busy", 32'(busy_a), 32'd0);
    check("ar_idle_addr", 32'(addr_a), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acu_sequencer.md
# acu_sequencer

Program sequencer that sits directly upstream of the accumulator ALU. It fetches 24-bit instruction words from a synchronous program ROM and issues opcode/operand pairs on the ALU's `op`/`data_in` inputs. It resolves jumps, including conditional jumps on the ALU's `zero` flag, and stops on HALT. It replaces the testbench driver as the ALU's stimulus source in the integrated accumulator datapath.

## Interface
- `AW`, 8: program address width; PC wraps modulo 2^AW.
- `START_ADDR`, 0: PC value loaded on reset and on every `start`.
- `ZERO_LAT`, 1: cycles from ALU op issue until `zero` reflects that op (range 0..7).

- `clk`, in, 1: single clock; all logic on rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: begin execution. Sampled only in IDLE or HALT.
- `instr_addr`, out, AW: ROM address; always equals the PC register.
- `instr_rdata`, in, 24: ROM data, valid one cycle after `instr_addr` is sampled. Bits [23:16] are the opcode; bits [15:0] are the immediate.
- `op`, out, 8: ALU opcode. 0x00 (NOP) whenever `op_valid`=0.
- `data_in`, out, 16: ALU operand. Holds its last issued value.
- `op_valid`, out, 1: one-cycle pulse per issued ALU op.
- `zero`, in, 1: ALU zero flag.
- `busy`, out, 1: high in FETCH/DECODE.
- `halted`, out, 1: high in HALT.
- `issue_cnt`, out, 16: number of ALU ops issued since reset; wraps at 0xFFFF to 0.

## Operation
- FSM states: IDLE, FETCH, DECODE, HALT.
- **IDLE**
  - `start`=1: load PC=START_ADDR, go to FETCH.
  - Otherwise remain in IDLE.
- **FETCH**: PC is on `instr_addr`. Go to DECODE unconditionally.
- **DECODE**: `instr_rdata` is valid. Action depends on the opcode:
  - 0x00 NOP: PC+1, go to FETCH; nothing is issued.
  - 0xF0 JMP: PC=imm[AW-1:0], go to FETCH.
  - 0xF1 JZ: if `zero`=1, PC=imm[AW-1:0]; else PC+1. Go to FETCH.
  - 0xF2 JNZ: if `zero`=0, PC=imm[AW-1:0]; else PC+1. Go to FETCH.
  - 0xFF HALT: go to HALT; PC stays on the HALT address.
  - Any other opcode (ALU op): register `op`=opcode and `data_in`=imm, pulse `op_valid`, increment `issue_cnt`, PC+1, go to FETCH.
- **Settle counter** (3 bits):
  - Loaded with ZERO_LAT on every issue.
  - Decrements by 1 each cycle while nonzero.
  - JZ/JNZ in DECODE with counter≠0: stall in DECODE. `instr_addr` is unchanged and the ROM re-presents the same word. The branch is evaluated on the first DECODE cycle with counter=0.
  - JMP, NOP, HALT and ALU ops never stall.
- **HALT**
  - `start`=1: PC=START_ADDR, go to FETCH. The settle counter is not cleared.
  - Otherwise remain in HALT.
- `start` is ignored in FETCH/DECODE.
- **PC arithmetic**: PC+1 is modulo 2^AW, so address 2^AW-1 is followed by address 0.
- Jump target bits imm[15:AW] are ignored.

## Timing
- Reset values (asynchronous):
  - state=IDLE, PC=START_ADDR, `instr_addr`=START_ADDR.
  - `op`=0x00, `data_in`=0x0000, `op_valid`=0.
  - `busy`=0, `halted`=0, `issue_cnt`=0, settle counter=0.
- All outputs are registered; no combinational path from input to output.
- **Start to first issue**: `start` sampled at edge E0 → FETCH after E0 → DECODE after E1 → `op_valid` high for the cycle after E2.
- **Throughput**: one instruction per 2 cycles, so back-to-back ALU ops pulse `op_valid` every other cycle.
- **Taken jump**: costs 2 cycles with no issue.
- **JZ/JNZ after an ALU op**:
  - ZERO_LAT≤1: no stall.
  - ZERO_LAT=N>1: N-1 extra DECODE cycles.
- **Reset mid-run**: `rst` asserted in any state returns all outputs to reset values immediately. An in-flight `op_valid` is cut short and is not counted.
- `zero` is sampled only on a DECODE edge that evaluates a branch.

## Test plan
- **Linear program**: ROM[0..2] = {0x01_0005, 0x02_0003, 0xFF_0000}, `start` pulse. Expect `op_valid` pulses 2 cycles apart carrying op/data 0x01/0x0005 then 0x02/0x0003, then `halted`=1, `issue_cnt`=2, `op`=0x00 between pulses.
- **Branch taken/not taken**: ROM[0] = 0x03_0000, ROM[1] = JZ 0x10. Drive `zero`=1 → next `instr_addr`=0x10. Repeat with `zero`=0 → next `instr_addr`=0x02. Repeat with JNZ; the results are inverted.
- **Settle stall**: ZERO_LAT=3, ALU op followed by JZ. Expect DECODE held 2 extra cycles with `instr_addr` stable, then the branch resolves using `zero` sampled at the final DECODE edge.
- **PC wrap**: START_ADDR=0xFE, ROM[0xFE] = NOP, ROM[0xFF] = ALU op, ROM[0x00] = HALT. Expect addresses 0xFE, 0xFF, 0x00, with the issue from 0xFF.
- **Halt/restart**: after HALT, `start` → refetch from START_ADDR. `start` pulsed while `busy` has no effect on the address sequence.
- **Async reset mid-run**: assert `rst` on the cycle `op_valid`=1. Expect `op_valid`=0, `issue_cnt`=0, state=IDLE and `instr_addr`=START_ADDR before the next clock edge.
